// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute control FSM for the 8-bit processor.
// Strobes are registered from the next state so they change together with `state`.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instruction,
  input  logic       Zflag,
  input  logic       Oflag,
  output logic       load_r0,
  output logic       load_r1,
  output logic       load_r2,
  output logic       load_r3,
  output logic       load_pc,
  output logic       inc_pc,
  output logic       load_ir,
  output logic       load_add_reg,
  output logic       load_reg_y,
  output logic       load_flags,
  output logic       write,
  output logic [2:0] sel_bus_1_mux,
  output logic [1:0] sel_bus_2_mux,
  output logic       halted,
  output logic [3:0] state
);

  localparam int unsigned OPW  = 4;
  localparam int unsigned RW   = 2;
  localparam int unsigned NREG = 4;
  localparam int unsigned S1W  = 3;
  localparam int unsigned S2W  = 2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_EX2  = 4'd5,
    S_MOV  = 4'd6,
    S_AD1  = 4'd7,
    S_AD2  = 4'd8,
    S_RD3  = 4'd9,
    S_WR3  = 4'd10,
    S_BR1  = 4'd11,
    S_BR2  = 4'd12,
    S_SKIP = 4'd13,
    S_HALT = 4'd14
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = 4'h0;
  localparam logic [OPW-1:0] OP_SUB  = 4'h1;
  localparam logic [OPW-1:0] OP_AND  = 4'h2;
  localparam logic [OPW-1:0] OP_NOT  = 4'h3;
  localparam logic [OPW-1:0] OP_MUL  = 4'h4;
  localparam logic [OPW-1:0] OP_OR   = 4'h5;
  localparam logic [OPW-1:0] OP_MOV  = 4'h8;
  localparam logic [OPW-1:0] OP_RD   = 4'h9;
  localparam logic [OPW-1:0] OP_WR   = 4'hA;
  localparam logic [OPW-1:0] OP_BR   = 4'hB;
  localparam logic [OPW-1:0] OP_BRZ  = 4'hC;
  localparam logic [OPW-1:0] OP_BRO  = 4'hD;
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  localparam logic [S1W-1:0] SEL1_PC   = 3'd4;
  localparam logic [S2W-1:0] SEL2_ALU  = 2'd0;
  localparam logic [S2W-1:0] SEL2_BUS1 = 2'd1;
  localparam logic [S2W-1:0] SEL2_MEM  = 2'd2;

  typedef struct packed {
    logic [NREG-1:0] load_r;
    logic            load_pc;
    logic            inc_pc;
    logic            load_ir;
    logic            load_add_reg;
    logic            load_reg_y;
    logic            load_flags;
    logic            write;
    logic [S1W-1:0]  sel1;
    logic [S2W-1:0]  sel2;
    logic            halted;
  } ctrl_t;

  state_t          state_q, state_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [OPW-1:0]  opcode;
  logic [RW-1:0]   src;
  logic [RW-1:0]   dest;
  logic [NREG-1:0] dest_oh;

  assign opcode  = instruction[7:4];
  assign src     = instruction[3:2];
  assign dest    = instruction[1:0];
  assign dest_oh = NREG'(1) << dest;

  // Next-state sequencing; opcode and flags are only consulted once IR is stable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: state_d = S_FET2;
      S_FET2: state_d = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND,
          OP_NOT, OP_MUL, OP_OR:  state_d = S_EX1;
          OP_MOV:                 state_d = S_MOV;
          OP_RD, OP_WR:           state_d = S_AD1;
          OP_BR:                  state_d = S_BR1;
          OP_BRZ:                 state_d = Zflag ? S_BR1 : S_SKIP;
          OP_BRO:                 state_d = Oflag ? S_BR1 : S_SKIP;
          OP_HALT:                state_d = S_HALT;
          default:                state_d = S_FET1;
        endcase
      end
      S_EX1:  state_d = S_EX2;
      S_EX2:  state_d = S_FET1;
      S_MOV:  state_d = S_FET1;
      S_AD1:  state_d = S_AD2;
      S_AD2:  state_d = (opcode == OP_RD) ? S_RD3 : S_WR3;
      S_RD3:  state_d = S_FET1;
      S_WR3:  state_d = S_FET1;
      S_BR1:  state_d = S_BR2;
      S_BR2:  state_d = S_FET1;
      S_SKIP: state_d = S_FET1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe decode for the state about to be entered.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FET1, S_AD1, S_BR1: begin
        ctrl_d.sel1         = SEL1_PC;
        ctrl_d.sel2         = SEL2_BUS1;
        ctrl_d.load_add_reg = 1'b1;
      end
      S_FET2: begin
        ctrl_d.sel2    = SEL2_MEM;
        ctrl_d.load_ir = 1'b1;
        ctrl_d.inc_pc  = 1'b1;
      end
      S_EX1: begin
        ctrl_d.sel1       = S1W'(src);
        ctrl_d.sel2       = SEL2_BUS1;
        ctrl_d.load_reg_y = 1'b1;
      end
      S_EX2: begin
        ctrl_d.sel1       = S1W'(dest);
        ctrl_d.sel2       = SEL2_ALU;
        ctrl_d.load_r     = dest_oh;
        ctrl_d.load_flags = 1'b1;
      end
      S_MOV: begin
        ctrl_d.sel1   = S1W'(src);
        ctrl_d.sel2   = SEL2_BUS1;
        ctrl_d.load_r = dest_oh;
      end
      S_AD2: begin
        ctrl_d.sel2         = SEL2_MEM;
        ctrl_d.load_add_reg = 1'b1;
        ctrl_d.inc_pc       = 1'b1;
      end
      S_RD3: begin
        ctrl_d.sel2   = SEL2_MEM;
        ctrl_d.load_r = dest_oh;
      end
      S_WR3: begin
        ctrl_d.sel1  = S1W'(src);
        ctrl_d.write = 1'b1;
      end
      S_BR2: begin
        ctrl_d.sel2    = SEL2_MEM;
        ctrl_d.load_pc = 1'b1;
      end
      S_SKIP: ctrl_d.inc_pc = 1'b1;
      S_HALT: ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign load_r0       = ctrl_q.load_r[0];
  assign load_r1       = ctrl_q.load_r[1];
  assign load_r2       = ctrl_q.load_r[2];
  assign load_r3       = ctrl_q.load_r[3];
  assign load_pc       = ctrl_q.load_pc;
  assign inc_pc        = ctrl_q.inc_pc;
  assign load_ir       = ctrl_q.load_ir;
  assign load_add_reg  = ctrl_q.load_add_reg;
  assign load_reg_y    = ctrl_q.load_reg_y;
  assign load_flags    = ctrl_q.load_flags;
  assign write         = ctrl_q.write;
  assign sel_bus_1_mux = ctrl_q.sel1;
  assign sel_bus_2_mux = ctrl_q.sel2;
  assign halted        = ctrl_q.halted;
  assign state         = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small behavioural datapath + memory is driven by the
// FSM strobes, and per-instruction results are compared with hand-computed values.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       Zflag, Oflag;
  logic       load_r0, load_r1, load_r2, load_r3;
  logic       load_pc, inc_pc, load_ir, load_add_reg, load_reg_y, load_flags, write;
  logic [2:0] sel_bus_1_mux;
  logic [1:0] sel_bus_2_mux;
  logic       halted;
  logic [3:0] state;

  control_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Zflag(Zflag), .Oflag(Oflag),
    .load_r0(load_r0), .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
    .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir), .load_add_reg(load_add_reg),
    .load_reg_y(load_reg_y), .load_flags(load_flags), .write(write),
    .sel_bus_1_mux(sel_bus_1_mux), .sel_bus_2_mux(sel_bus_2_mux),
    .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath and memory model
  logic [7:0]  r [4];
  logic [7:0]  mem [256];
  logic [7:0]  init_r [4];
  logic [7:0]  init_mem [256];
  logic        init_zf, init_of;
  logic [7:0]  pc, ir, add_reg, reg_y;
  logic        zf, of;
  logic [7:0]  bus_1, bus_2, alu_res;
  logic        alu_ovf;
  logic [15:0] prod;
  logic [3:0]  loads;
  logic [16:0] strobes;

  assign loads       = {load_r3, load_r2, load_r1, load_r0};
  assign strobes     = {loads, load_pc, inc_pc, load_ir, load_add_reg, load_reg_y,
                        load_flags, write, sel_bus_1_mux, sel_bus_2_mux, halted};
  assign instruction = ir;
  assign Zflag       = zf;
  assign Oflag       = of;

  always_comb begin
    case (sel_bus_1_mux)
      3'd0:    bus_1 = r[0];
      3'd1:    bus_1 = r[1];
      3'd2:    bus_1 = r[2];
      3'd3:    bus_1 = r[3];
      3'd4:    bus_1 = pc;
      default: bus_1 = 8'h00;
    endcase
  end

  always_comb begin
    alu_res = 8'h00;
    alu_ovf = 1'b0;
    prod    = 16'(reg_y) * 16'(bus_1);
    case (ir[7:4])
      4'h0: {alu_ovf, alu_res} = 9'(reg_y) + 9'(bus_1);
      4'h1: {alu_ovf, alu_res} = 9'(reg_y) - 9'(bus_1);
      4'h2: alu_res = reg_y & bus_1;
      4'h3: alu_res = ~reg_y;
      4'h4: begin alu_res = prod[7:0]; alu_ovf = |prod[15:8]; end
      4'h5: alu_res = reg_y | bus_1;
      default: alu_res = 8'h00;
    endcase
  end

  always_comb begin
    case (sel_bus_2_mux)
      2'd0:    bus_2 = alu_res;
      2'd1:    bus_2 = bus_1;
      2'd2:    bus_2 = mem[add_reg];
      default: bus_2 = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r[i] <= init_r[i];
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
      pc <= 8'h00; ir <= 8'h00; add_reg <= 8'h00; reg_y <= 8'h00;
      zf <= init_zf; of <= init_of;
    end else begin
      for (int i = 0; i < 4; i++) if (loads[i]) r[i] <= bus_2;
      if (load_pc) pc <= bus_2;
      else if (inc_pc) pc <= pc + 8'd1;
      if (load_ir) ir <= bus_2;
      if (load_add_reg) add_reg <= bus_2;
      if (load_reg_y) reg_y <= bus_2;
      if (load_flags) begin zf <= (alu_res == 8'h00); of <= alu_ovf; end
      if (write) mem[add_reg] <= bus_1;
    end
  end

  // Strobe activity counters, cleared while in reset
  int cnt_flags, cnt_write, cnt_skip, cnt_excl;
  always @(negedge clk) begin
    if (!rst) begin
      cnt_flags <= 0; cnt_write <= 0; cnt_skip <= 0; cnt_excl <= 0;
    end else begin
      if (load_flags) cnt_flags <= cnt_flags + 1;
      if (write) cnt_write <= cnt_write + 1;
      if (state == 4'd13) cnt_skip <= cnt_skip + 1;
      if ((load_pc && inc_pc) || (write && (|loads)) || ($countones(loads) > 1))
        cnt_excl <= cnt_excl + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_init();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'hF0;
    for (int i = 0; i < 4; i++) init_r[i] = 8'h00;
    init_zf = 1'b0;
    init_of = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int p0, p1, da, dv;
    int r0, r1, r2, r3;
    int zf0, of0;
    int cyc, pc;
    int ridx, rval, ez;
    int nf, nw, ns;
    int cm, ma, mv;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    logic [16:0] acc_or;
    logic        acc_halt;
    int          cycles;
    int          pulses;
    int          pulse_state;
    string       nm;

    rst = 1'b0;
    clear_init();

    //              p0    p1    da    dv    r0    r1    r2    r3  zf of cyc   pc  ri rval  ez nf nw ns cm  ma    mv
    vecs[0]  = '{'hE0, 'hF0, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 0, 0,  7, 'h02, 0, 'h11, 0, 0, 0, 0, 0, 0,    0};
    vecs[1]  = '{'h60, 'hF0, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 1, 0,  7, 'h02, 1, 'h22, 1, 0, 0, 0, 0, 0,    0};
    vecs[2]  = '{'h7F, 'hF0, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 0, 1,  7, 'h02, 3, 'h44, 0, 0, 0, 0, 0, 0,    0};
    vecs[3]  = '{'hF0, 'hF0, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 0, 0,  4, 'h01, 2, 'h33, 0, 0, 0, 0, 0, 0,    0};
    vecs[4]  = '{'h8E, 'hF0, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h77, 1, 0,  8, 'h02, 2, 'h77, 1, 0, 0, 0, 0, 0,    0};
    vecs[5]  = '{'h01, 'hF0, 'hFF, 'hF0, 'h03, 'h04, 'h33, 'h44, 1, 0,  9, 'h02, 1, 'h07, 0, 1, 0, 0, 0, 0,    0};
    vecs[6]  = '{'h15, 'hF0, 'hFF, 'hF0, 'h11, 'h05, 'h33, 'h44, 0, 0,  9, 'h02, 1, 'h00, 1, 1, 0, 0, 0, 0,    0};
    vecs[7]  = '{'h2B, 'hF0, 'hFF, 'hF0, 'h11, 'h22, 'hF0, 'h3C, 1, 0,  9, 'h02, 3, 'h30, 0, 1, 0, 0, 0, 0,    0};
    vecs[8]  = '{'h36, 'hF0, 'hFF, 'hF0, 'h11, 'h0F, 'h33, 'h44, 1, 0,  9, 'h02, 2, 'hF0, 0, 1, 0, 0, 0, 0,    0};
    vecs[9]  = '{'h41, 'hF0, 'hFF, 'hF0, 'h03, 'h04, 'h33, 'h44, 1, 0,  9, 'h02, 1, 'h0C, 0, 1, 0, 0, 0, 0,    0};
    vecs[10] = '{'h5B, 'hF0, 'hFF, 'hF0, 'h11, 'h22, 'hF0, 'h0F, 1, 0,  9, 'h02, 3, 'hFF, 0, 1, 0, 0, 0, 0,    0};
    vecs[11] = '{'h91, 'h10, 'h10, 'h05, 'h11, 'h22, 'h33, 'h44, 0, 0, 10, 'h03, 1, 'h05, 0, 0, 0, 0, 0, 0,    0};
    vecs[12] = '{'hA8, 'h30, 'hFF, 'hF0, 'h11, 'h22, 'h5A, 'h44, 0, 0, 10, 'h03, 2, 'h5A, 0, 0, 1, 0, 1, 'h30, 'h5A};
    vecs[13] = '{'hB0, 'h20, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 0, 0,  9, 'h21, 0, 'h11, 0, 0, 0, 0, 0, 0,    0};
    vecs[14] = '{'hC0, 'h20, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 1, 0,  9, 'h21, 0, 'h11, 1, 0, 0, 0, 0, 0,    0};
    vecs[15] = '{'hC0, 'h20, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 0, 1,  8, 'h03, 0, 'h11, 0, 0, 0, 1, 0, 0,    0};
    vecs[16] = '{'hD0, 'h20, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 0, 1,  9, 'h21, 0, 'h11, 0, 0, 0, 0, 0, 0,    0};
    vecs[17] = '{'hD0, 'h20, 'hFF, 'hF0, 'h11, 'h22, 'h33, 'h44, 1, 0,  8, 'h03, 0, 'h11, 1, 0, 0, 1, 0, 0,    0};

    // Reset values and the first fetch cycle
    clear_init();
    init_mem[0] = 8'hE0;
    do_reset();
    check("reset strobes", 32'(strobes), 32'h0);
    check("reset state", 32'(state), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("first state", 32'(state), 32'd1);
    check("first strobes", 32'(strobes), 32'(17'b0000_0001000_100_01_0));

    // One program per table row, each terminated by the HALT that fills memory
    for (int i = 0; i < NV; i++) begin
      nm = $sformatf("v%0d", i);
      clear_init();
      init_mem[8'(vecs[i].da)] = 8'(vecs[i].dv);
      init_mem[0] = 8'(vecs[i].p0);
      init_mem[1] = 8'(vecs[i].p1);
      init_r[0] = 8'(vecs[i].r0); init_r[1] = 8'(vecs[i].r1);
      init_r[2] = 8'(vecs[i].r2); init_r[3] = 8'(vecs[i].r3);
      init_zf = 1'(vecs[i].zf0);
      init_of = 1'(vecs[i].of0);
      do_reset();
      rst = 1'b1;
      cycles = 0;
      do begin
        @(posedge clk); #1;
        cycles++;
      end while (!halted && cycles < 40);
      check({nm, " cycles"}, 32'(cycles), vecs[i].cyc);
      check({nm, " pc"}, 32'(pc), vecs[i].pc);
      check({nm, " reg"}, 32'(r[vecs[i].ridx]), vecs[i].rval);
      check({nm, " zflag"}, 32'(zf), vecs[i].ez);
      check({nm, " flag loads"}, cnt_flags, vecs[i].nf);
      check({nm, " writes"}, cnt_write, vecs[i].nw);
      check({nm, " skips"}, cnt_skip, vecs[i].ns);
      check({nm, " exclusivity"}, cnt_excl, 0);
      if (vecs[i].cm != 0) check({nm, " mem"}, 32'(mem[8'(vecs[i].ma)]), vecs[i].mv);
    end

    // RD cycle by cycle: single load_r1 pulse in S_RD3, PC=2 at next fetch
    clear_init();
    init_mem[0] = 8'h91; init_mem[1] = 8'h10; init_mem[8'h10] = 8'h05;
    do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    pulses = 0; pulse_state = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (load_r1) begin pulses++; pulse_state = 32'(state); end
    end
    check("rd load_r1 pulses", pulses, 1);
    check("rd pulse state", pulse_state, 9);
    check("rd back to fetch", 32'(state), 1);
    check("rd pc", 32'(pc), 32'h02);
    check("rd r1", 32'(r[1]), 32'h05);

    // ALU result feeding a following BRZ: taken after SUB-to-zero, skipped after ADD
    for (int k = 0; k < 2; k++) begin
      clear_init();
      init_mem[0] = (k == 0) ? 8'h15 : 8'h01;
      init_mem[1] = 8'hC0; init_mem[2] = 8'h20;
      init_r[0] = 8'h03;
      init_r[1] = (k == 0) ? 8'h05 : 8'h04;
      init_zf = (k == 0) ? 1'b0 : 1'b1;
      do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      repeat (5) @(posedge clk); #1;
      check($sformatf("seq%0d zflag", k), 32'(zf), (k == 0) ? 1 : 0);
      check($sformatf("seq%0d alu fetch", k), 32'(state), 1);
      repeat ((k == 0) ? 5 : 4) @(posedge clk); #1;
      check($sformatf("seq%0d br fetch", k), 32'(state), 1);
      check($sformatf("seq%0d pc", k), 32'(pc), (k == 0) ? 32'h20 : 32'h03);
      check($sformatf("seq%0d skips", k), cnt_skip, (k == 0) ? 0 : 1);
    end

    // HALT holds quietly, then an async reset drops halted mid-cycle
    clear_init();
    do_reset();
    rst = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!halted && cycles < 10);
    check("halt state", 32'(state), 32'd14);
    acc_or = '0; acc_halt = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      acc_or   = acc_or | {strobes[16:1], 1'b0};
      acc_halt = acc_halt & halted;
    end
    check("halt strobes quiet", 32'(acc_or), 32'h0);
    check("halt held", 32'(acc_halt), 32'h1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async halted", 32'(halted), 32'h0);
    check("async state", 32'(state), 32'h0);

    // Async reset in S_EX2 kills the in-flight register and flag loads at once
    clear_init();
    init_mem[0] = 8'h01; init_r[0] = 8'h03; init_r[1] = 8'h04;
    do_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("ex2 reached", 32'(state), 32'd5);
    check("ex2 flags strobe", 32'(load_flags), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("ex2 reset strobes", 32'(strobes), 32'h0);
    check("ex2 reset state", 32'(state), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
